// File: rtl/pulse_channel_generator_pkg.sv
// Shared tables and helpers for the GB-style sound channels: duty patterns,
// frame-sequencer step masks, DAC enable and sweep arithmetic.
package pulse_channel_generator_pkg;

    // Bit n set = that clock is issued when frame_step == n.
    localparam logic [7:0] LEN_STEP_MASK   = 8'b0101_0101;
    localparam logic [7:0] SWEEP_STEP_MASK = 8'b0100_0100;
    localparam logic [7:0] ENV_STEP_MASK   = 8'b1000_0000;

    typedef enum logic [1:0] {
        DUTY_12 = 2'b00,
        DUTY_25 = 2'b01,
        DUTY_50 = 2'b10,
        DUTY_75 = 2'b11
    } duty_e;

    typedef struct packed {
        logic        kill;
        logic        wr;
        logic [10:0] val;
    } sweep_res_t;

    function automatic logic [7:0] duty_pattern(input logic [1:0] duty);
        logic [7:0] pat;
        case (duty_e'(duty))
            DUTY_12: pat = 8'b0000_0001;
            DUTY_25: pat = 8'b1000_0001;
            DUTY_50: pat = 8'b1000_0111;
            default: pat = 8'b0111_1110;
        endcase
        return pat;
    endfunction

    function automatic logic dac_on(input logic [3:0] vol, input logic dir);
        return (vol != 4'd0) || dir;
    endfunction

    // Bit 11 of the result flags overflow past 2047; subtract cannot go negative.
    function automatic logic [11:0] sweep_calc(input logic [10:0] f, input logic [2:0] sh,
                                               input logic sub);
        logic [11:0] d;
        d = {1'b0, f >> sh};
        return sub ? ({1'b0, f} - d) : ({1'b0, f} + d);
    endfunction

endpackage

// File: rtl/pulse_channel_generator_envelope.sv
// Volume envelope: loads on trigger, steps volume by one on each timer expiry,
// saturating at 0/15. Shared with the noise channel.
module sound_envelope_unit (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       load_i,
    input  logic       clk_en_i,
    input  logic [3:0] init_vol_i,
    input  logic       dir_i,
    input  logic [2:0] period_i,
    output logic [3:0] volume_o
);

    logic [3:0] vol_q, vol_d;
    logic [2:0] timer_q, timer_d;

    always_comb begin
        vol_d   = vol_q;
        timer_d = timer_q;
        if (load_i) begin
            vol_d   = init_vol_i;
            timer_d = period_i;
        end else if (clk_en_i && (period_i != 3'd0)) begin
            if (timer_q <= 3'd1) begin
                timer_d = period_i;
                if (dir_i && (vol_q != 4'hF))
                    vol_d = vol_q + 4'd1;
                else if (!dir_i && (vol_q != 4'h0))
                    vol_d = vol_q - 4'd1;
            end else begin
                timer_d = timer_q - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vol_q   <= '0;
            timer_q <= '0;
        end else begin
            vol_q   <= vol_d;
            timer_q <= timer_d;
        end
    end

    assign volume_o = vol_q;

endmodule

// File: rtl/pulse_channel_generator.sv
// Pulse (square) sound channel: duty sequencer, length counter, envelope and
// optional frequency sweep, all paced by enable strobes in one clock domain.
module pulse_channel_generator
    import pulse_channel_generator_pkg::*;
#(
    parameter int SAMPLE_W  = 20,
    parameter int VOL_SHIFT = 3,
    parameter int SWEEP_EN  = 1
) (
    input  logic                I_CLK_33MHZ,
    input  logic                I_RESET_N,
    input  logic                I_TICK,
    input  logic                I_FRAME_TICK,
    input  logic                I_STROBE,
    input  logic                I_TRIGGER,
    input  logic [10:0]         I_FREQUENCY,
    input  logic [1:0]          I_DUTY_CYCLE,
    input  logic [3:0]          I_VOLUME,
    input  logic                I_ENV_DIR,
    input  logic [2:0]          I_ENV_PERIOD,
    input  logic [5:0]          I_LENGTH,
    input  logic                I_LENGTH_EN,
    input  logic [2:0]          I_SWEEP_PERIOD,
    input  logic                I_SWEEP_DIR,
    input  logic [2:0]          I_SWEEP_SHIFT,
    output logic [SAMPLE_W-1:0] O_SAMPLE,
    output logic                O_ACTIVE,
    output logic [10:0]         O_FREQUENCY
);

    localparam int AMP_STEP = ((1 << (SAMPLE_W - 1)) - 1) / 15;

    logic                active_q, active_d;
    logic [10:0]         shadow_q, shadow_d;
    logic [11:0]         ftimer_q, ftimer_d;
    logic [2:0]          duty_pos_q, duty_pos_d;
    logic [2:0]          frame_step_q, frame_step_d;
    logic [6:0]          length_q, length_d;
    logic [SAMPLE_W-1:0] sample_q, sample_d;

    logic       dac;
    logic       step_hit, len_clk, sweep_clk, env_clk;
    logic       len_kill;
    logic [3:0] volume;
    logic [7:0] duty_pat;
    logic [SAMPLE_W-1:0] amp;
    sweep_res_t sw_res;
    logic       trig_ovf;

    assign dac      = dac_on(I_VOLUME, I_ENV_DIR);
    assign O_ACTIVE = active_q & dac;

    // A trigger swallows the sequencer clock of its cycle, but the step still advances.
    assign step_hit  = I_FRAME_TICK & ~I_TRIGGER;
    assign len_clk   = step_hit & LEN_STEP_MASK[frame_step_q];
    assign sweep_clk = step_hit & SWEEP_STEP_MASK[frame_step_q];
    assign env_clk   = step_hit & ENV_STEP_MASK[frame_step_q];

    assign frame_step_d = I_FRAME_TICK ? frame_step_q + 3'd1 : frame_step_q;

    always_comb begin
        ftimer_d   = ftimer_q;
        duty_pos_d = duty_pos_q;
        if (I_TRIGGER) begin
            ftimer_d = 12'd2048 - {1'b0, I_FREQUENCY};
        end else if (I_TICK) begin
            if (ftimer_q <= 12'd1) begin
                ftimer_d   = 12'd2048 - {1'b0, shadow_q};
                duty_pos_d = duty_pos_q + 3'd1;
            end else begin
                ftimer_d = ftimer_q - 12'd1;
            end
        end
    end

    always_comb begin
        length_d = length_q;
        len_kill = 1'b0;
        if (I_TRIGGER) begin
            if (length_q == 7'd0)
                length_d = 7'd64 - {1'b0, I_LENGTH};
        end else if (len_clk && I_LENGTH_EN && (length_q != 7'd0)) begin
            length_d = length_q - 7'd1;
            len_kill = (length_q == 7'd1);
        end
    end

    generate
        if (SWEEP_EN != 0) begin : g_sweep
            logic [3:0]  stimer_q, stimer_d;
            logic        son_q, son_d;
            logic [3:0]  reload;
            logic [11:0] nf, nf2, tf;

            assign reload   = (I_SWEEP_PERIOD == 3'd0) ? 4'd8 : {1'b0, I_SWEEP_PERIOD};
            assign nf       = sweep_calc(shadow_q, I_SWEEP_SHIFT, I_SWEEP_DIR);
            assign nf2      = sweep_calc(nf[10:0], I_SWEEP_SHIFT, I_SWEEP_DIR);
            assign tf       = sweep_calc(I_FREQUENCY, I_SWEEP_SHIFT, I_SWEEP_DIR);
            assign trig_ovf = (I_SWEEP_SHIFT != 3'd0) && tf[11];

            always_comb begin
                stimer_d = stimer_q;
                son_d    = son_q;
                sw_res   = '0;
                if (I_TRIGGER) begin
                    stimer_d = reload;
                    son_d    = (I_SWEEP_PERIOD != 3'd0) || (I_SWEEP_SHIFT != 3'd0);
                end else if (sweep_clk) begin
                    if (stimer_q <= 4'd1) begin
                        stimer_d = reload;
                        if (son_q && (I_SWEEP_PERIOD != 3'd0)) begin
                            if (nf[11]) begin
                                sw_res.kill = 1'b1;
                            end else if (I_SWEEP_SHIFT != 3'd0) begin
                                // Store the first result, then only probe the next one.
                                sw_res.wr   = 1'b1;
                                sw_res.val  = nf[10:0];
                                sw_res.kill = nf2[11];
                            end
                        end
                    end else begin
                        stimer_d = stimer_q - 4'd1;
                    end
                end
            end

            always_ff @(posedge I_CLK_33MHZ) begin
                if (!I_RESET_N) begin
                    stimer_q <= '0;
                    son_q    <= 1'b0;
                end else begin
                    stimer_q <= stimer_d;
                    son_q    <= son_d;
                end
            end
        end else begin : g_no_sweep
            assign sw_res   = '0;
            assign trig_ovf = 1'b0;
        end
    endgenerate

    always_comb begin
        shadow_d = shadow_q;
        active_d = active_q;
        if (I_TRIGGER) begin
            shadow_d = I_FREQUENCY;
            active_d = dac & ~trig_ovf;
        end else begin
            if (sw_res.wr)
                shadow_d = sw_res.val;
            if (len_kill || sw_res.kill)
                active_d = 1'b0;
        end
        if (!dac)
            active_d = 1'b0;
    end

    sound_envelope_unit u_env (
        .clk_i      (I_CLK_33MHZ),
        .rst_ni     (I_RESET_N),
        .load_i     (I_TRIGGER),
        .clk_en_i   (env_clk),
        .init_vol_i (I_VOLUME),
        .dir_i      (I_ENV_DIR),
        .period_i   (I_ENV_PERIOD),
        .volume_o   (volume)
    );

    assign duty_pat = duty_pattern(I_DUTY_CYCLE);
    assign amp      = SAMPLE_W'((32'(volume) * AMP_STEP) >> VOL_SHIFT);

    always_comb begin
        sample_d = sample_q;
        if (I_STROBE)
            sample_d = !O_ACTIVE ? '0 : (duty_pat[duty_pos_q] ? amp : -amp);
    end

    always_ff @(posedge I_CLK_33MHZ) begin
        if (!I_RESET_N) begin
            active_q     <= 1'b0;
            shadow_q     <= '0;
            ftimer_q     <= '0;
            duty_pos_q   <= '0;
            frame_step_q <= '0;
            length_q     <= '0;
            sample_q     <= '0;
        end else begin
            active_q     <= active_d;
            shadow_q     <= shadow_d;
            ftimer_q     <= ftimer_d;
            duty_pos_q   <= duty_pos_d;
            frame_step_q <= frame_step_d;
            length_q     <= length_d;
            sample_q     <= sample_d;
        end
    end

    assign O_SAMPLE    = sample_q;
    assign O_FREQUENCY = shadow_q;

endmodule

// File: tb/tb_pulse_channel_generator.sv
// Pulse channel bench: directed scenarios plus random traffic, every cycle
// compared against a behavioural model of the channel.
module tb_pulse_channel_generator;

    localparam int SAMPLE_W  = 20;
    localparam int VOL_SHIFT = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n = 1'b0, tick = 1'b0, frame = 1'b0, strobe = 1'b0, trig = 1'b0;
    logic [10:0]         freq = '0;
    logic [1:0]          duty = '0;
    logic [3:0]          vol = '0;
    logic                edir = 1'b0;
    logic [2:0]          eper = '0;
    logic [5:0]          len = '0;
    logic                len_en = 1'b0;
    logic [2:0]          sper = '0;
    logic                sdir = 1'b0;
    logic [2:0]          ssh = '0;
    logic [SAMPLE_W-1:0] sample;
    logic                active;
    logic [10:0]         ofreq;

    pulse_channel_generator #(.SAMPLE_W(SAMPLE_W), .VOL_SHIFT(VOL_SHIFT), .SWEEP_EN(1)) dut (
        .I_CLK_33MHZ(clk), .I_RESET_N(rst_n), .I_TICK(tick), .I_FRAME_TICK(frame),
        .I_STROBE(strobe), .I_TRIGGER(trig), .I_FREQUENCY(freq), .I_DUTY_CYCLE(duty),
        .I_VOLUME(vol), .I_ENV_DIR(edir), .I_ENV_PERIOD(eper), .I_LENGTH(len),
        .I_LENGTH_EN(len_en), .I_SWEEP_PERIOD(sper), .I_SWEEP_DIR(sdir), .I_SWEEP_SHIFT(ssh),
        .O_SAMPLE(sample), .O_ACTIVE(active), .O_FREQUENCY(ofreq)
    );

    int errors = 0;
    int checks = 0;

    int m_active, m_shadow, m_ftimer, m_pos, m_step, m_len, m_vol, m_etimer, m_stimer, m_swon, m_sample;
    int pat [4] = '{32'h01, 32'h81, 32'h87, 32'h7E};

    task automatic chk(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sw(input int f);
        int d;
        d = f >> ssh;
        return sdir ? f - d : f + d;
    endfunction

    task automatic model_step();
        int dac, so, nf, a;
        if (!rst_n) begin
            m_active = 0; m_shadow = 0; m_ftimer = 0; m_pos = 0; m_step = 0; m_len = 0;
            m_vol = 0; m_etimer = 0; m_stimer = 0; m_swon = 0; m_sample = 0;
            return;
        end
        dac = (vol != 0 || edir) ? 1 : 0;
        a = (m_vol * (((1 << (SAMPLE_W - 1)) - 1) / 15)) >> VOL_SHIFT;
        if (strobe)
            m_sample = (m_active != 0 && dac != 0) ? ((((pat[duty] >> m_pos) & 1) != 0) ? a : -a) : 0;
        so = m_step;
        if (frame) m_step = (m_step + 1) % 8;
        if (trig) begin
            m_active = dac;
            m_shadow = freq;
            m_ftimer = 2048 - freq;
            m_vol    = vol;
            m_etimer = eper;
            if (m_len == 0) m_len = 64 - len;
            m_stimer = (sper == 0) ? 8 : sper;
            m_swon   = (sper != 0 || ssh != 0) ? 1 : 0;
            if (ssh != 0 && sw(freq) > 2047) m_active = 0;
        end else begin
            if (tick) begin
                if (m_ftimer <= 1) begin
                    m_ftimer = 2048 - m_shadow;
                    m_pos = (m_pos + 1) % 8;
                end else m_ftimer--;
            end
            if (frame && (so % 2 == 0) && len_en && m_len != 0) begin
                m_len--;
                if (m_len == 0) m_active = 0;
            end
            if (frame && (so == 2 || so == 6)) begin
                if (m_stimer <= 1) begin
                    m_stimer = (sper == 0) ? 8 : sper;
                    if (m_swon != 0 && sper != 0) begin
                        nf = sw(m_shadow);
                        if (nf > 2047) m_active = 0;
                        else if (ssh != 0) begin
                            m_shadow = nf;
                            if (sw(nf) > 2047) m_active = 0;
                        end
                    end
                end else m_stimer--;
            end
            if (frame && so == 7 && eper != 0) begin
                if (m_etimer <= 1) begin
                    m_etimer = eper;
                    if (edir) m_vol = (m_vol < 15) ? m_vol + 1 : 15;
                    else      m_vol = (m_vol > 0) ? m_vol - 1 : 0;
                end else m_etimer--;
            end
        end
        if (!dac) m_active = 0;
    endtask

    // One clock: model advances on the edge, DUT sampled 1 ns later, strobes dropped.
    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        chk("sample", $signed(sample), m_sample);
        chk("active", {31'd0, active}, m_active);
        chk("freq", {21'd0, ofreq}, m_shadow);
        tick = 0; frame = 0; strobe = 0; trig = 0;
    endtask

    task automatic set_regs(input int f, input int d, input int v, input int ed, input int ep,
                            input int l, input int le, input int sp, input int sd, input int sh);
        freq = 11'(f); duty = 2'(d); vol = 4'(v); edir = 1'(ed); eper = 3'(ep);
        len = 6'(l); len_en = 1'(le); sper = 3'(sp); sdir = 1'(sd); ssh = 3'(sh);
    endtask

    task automatic do_reset();
        rst_n = 0; cycle(); rst_n = 1;
    endtask

    task automatic frame_pulses(input int n, input int gap);
        for (int i = 0; i < n; i++) begin
            frame = 1; strobe = 1; cycle();
            for (int j = 0; j < gap; j++) cycle();
        end
    endtask

    initial begin
        int mag;
        rst_n = 0; cycle(); cycle();
        chk("rst_sample", $signed(sample), 0);
        chk("rst_active", {31'd0, active}, 0);
        chk("rst_freq", {21'd0, ofreq}, 0);
        rst_n = 1;

        // Duty 50% at the fastest rate, strobe every tick.
        set_regs(2047, 2, 15, 0, 0, 0, 0, 0, 0, 0);
        trig = 1; cycle();
        for (int i = 0; i < 16; i++) begin tick = 1; strobe = 1; cycle(); end
        mag = ($signed(sample) < 0) ? -$signed(sample) : $signed(sample);
        chk("duty_amp", mag, 32'h0FFFF);

        // Reset mid-play silences the channel until the next trigger.
        do_reset();
        for (int i = 0; i < 4; i++) begin tick = 1; strobe = 1; cycle(); end
        chk("midrst_active", {31'd0, active}, 0);
        chk("midrst_sample", $signed(sample), 0);

        // Length 62 from step 0: expires on the third frame tick.
        set_regs(2000, 1, 15, 0, 0, 62, 1, 0, 0, 0);
        trig = 1; cycle();
        frame_pulses(2, 3);
        chk("len_before", {31'd0, active}, 1);
        frame_pulses(1, 3);
        chk("len_after", {31'd0, active}, 0);
        frame_pulses(1, 3);

        // Envelope decay to zero, then hold.
        do_reset();
        set_regs(2047, 2, 2, 0, 1, 0, 0, 0, 0, 0);
        trig = 1; cycle();
        frame_pulses(16, 2);
        strobe = 1; cycle(); cycle();
        chk("env_zero", $signed(sample), 0);
        chk("env_active", {31'd0, active}, 1);

        // Trigger-time sweep overflow: 1800 + 900 > 2047.
        set_regs(1800, 2, 15, 0, 0, 0, 0, 1, 0, 1);
        trig = 1; cycle();
        chk("sweep_ovf", {31'd0, active}, 0);

        // DAC off: trigger cannot start the channel.
        set_regs(1000, 2, 0, 0, 0, 0, 0, 0, 0, 0);
        trig = 1; cycle();
        chk("dac_off_act", {31'd0, active}, 0);
        strobe = 1; cycle(); cycle();
        chk("dac_off_smp", $signed(sample), 0);

        // Random traffic.
        for (int i = 0; i < 15000; i++) begin
            if ($urandom_range(0, 399) == 0 || trig)
                set_regs($urandom_range(0, 3) == 0 ? $urandom_range(0, 2047) : $urandom_range(1700, 2047),
                         $urandom_range(0, 3),
                         $urandom_range(0, 5) == 0 ? 0 : $urandom_range(1, 15),
                         $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 63),
                         $urandom_range(0, 1), $urandom_range(0, 7), $urandom_range(0, 1),
                         $urandom_range(0, 7));
            tick   = 1'($urandom_range(0, 1));
            frame  = ($urandom_range(0, 11) == 0);
            strobe = ($urandom_range(0, 3) == 0);
            trig   = ($urandom_range(0, 149) == 0);
            rst_n  = ($urandom_range(0, 2999) != 0);
            cycle();
            rst_n = 1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
